alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  16  operands from requester N.
REQ-007 req0_op / req1_op  input  4  opcode: 0001 add, 0010 sub, 0011 mul, 0100 div.
REQ-008 alu_a, alu_b  output  16  registered operands to the shared ALU.
REQ-009 alu_op  output  4  registered opcode to the shared ALU.
REQ-010 alu_result  input  16  combinational ALU result.
REQ-011 rsp_valid  output  1  one-cycle pulse: response present.
REQ-012 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-013 rsp_result  output  16  captured result.
REQ-014 rsp_err  output  1  operation rejected (illegal opcode, or divide by zero when enabled).

Function
REQ-015 FSM states SHALL be IDLE, EXEC and DONE; they transition IDLE->EXEC on accept, EXEC->DONE always, and DONE->IDLE always.
REQ-016 reqN_ready SHALL be asserted only in IDLE, for at most one requester; a transfer occurs when valid and ready are both high at a rising edge.
REQ-017 Arbitration is round-robin: with a single valid, that requester is granted; with both valid, the requester not granted last is granted; the last-grant register resets to 1, so req0 wins the first tie.
REQ-018 On transfer, the operands, opcode and grant id SHALL be latched; alu_a, alu_b and alu_op SHALL present the latched values from the cycle after accept (EXEC).
REQ-019 alu_result SHALL be sampled at the end of EXEC; rsp_valid, rsp_id, rsp_result and rsp_err SHALL be valid during DONE only.
REQ-020 Latency: accept at edge T -> rsp_valid high in cycle T+2; the next accept occurs no earlier than edge T+3 (one op per 3 cycles max).
REQ-021 An opcode outside 0001-0100 SHALL produce rsp_err=1 and rsp_result=0x0000, with alu_op driven 0000 during EXEC.
REQ-022 The arithmetic width is 16 bits; overflow, underflow and truncation SHALL pass through from the ALU unchanged, with no error flagged.
REQ-023 Requests arriving while the FSM is in EXEC or DONE SHALL be held off (ready=0), never dropped; requesters hold valid and data until accepted.
REQ-024 Outside DONE, rsp_valid=0; rsp_result, rsp_id and rsp_err hold their last values.

Reset
REQ-025 rst SHALL force state IDLE, last-grant=1, and every output to 0 (ready, alu_a, alu_b, alu_op=0000, rsp_valid, rsp_id, rsp_result, rsp_err).
REQ-026 rst asserted during EXEC or DONE SHALL abort the operation, with no rsp_valid issued for it.
REQ-027 The first accept after reset release SHALL occur no earlier than the first edge with rst low.

Configuration
REQ-028 Macro DIV_ZERO_CHECK_EN: when defined, opcode 0100 with b=0 SHALL yield rsp_err=1 and rsp_result=0xFFFF, with alu_op driven 0000 during EXEC; the latency is unchanged.
REQ-029 Without DIV_ZERO_CHECK_EN, divide by zero SHALL be issued to the ALU normally, with rsp_result=alu_result and rsp_err=0.

Verification
REQ-030 req0 only: a=10, b=3, op=0001 -> req0_ready in the same cycle, rsp_valid 2 cycles after accept, with rsp_id=0, rsp_result=13, rsp_err=0.
REQ-031 Back-to-back req1: op 0010 (10,3), then 0011 (6,7), then 0100 (20,4) -> responses 7, 42, 5, each with rsp_id=1 and accepts spaced 3 cycles apart.
REQ-032 Both valid continuously after reset -> grants alternate 0,1,0,1; no requester is starved.
REQ-033 Illegal opcode 1111 -> rsp_err=1, rsp_result=0; with DIV_ZERO_CHECK_EN, op 0100 (5,0) -> rsp_err=1, rsp_result=0xFFFF, and without the macro rsp_err=0.
REQ-034 rst pulsed in EXEC -> no rsp_valid for that operation; all outputs are 0 the next cycle; req0 wins the next tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin 2-requester front end for a shared 16-bit ALU; `DIV_ZERO_CHECK_EN traps divide by zero
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;
    logic last, id_q, err_q, dz_q, sel, go, legal, dz;
    logic [15:0] a, b;
    logic [3:0] op;
    // last=1 means req1 was granted most recently, so req0 wins the next tie
    always_comb begin
        req0_ready = state == IDLE && !rst && req0_valid && (!req1_valid || last);
        req1_ready = state == IDLE && !rst && req1_valid && (!req0_valid || !last);
        go = req0_ready | req1_ready;
        sel = req1_ready;
        a = sel ? req1_a : req0_a;
        b = sel ? req1_b : req0_b;
        op = sel ? req1_op : req0_op;
        legal = op >= 4'd1 && op <= 4'd4;
`ifdef DIV_ZERO_CHECK_EN
        dz = op == 4'd4 && b == 16'd0;
`else
        dz = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
            id_q <= 1'b0;
            err_q <= 1'b0;
            dz_q <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_result <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state <= EXEC;
                    last <= sel;
                    id_q <= sel;
                    alu_a <= a;
                    alu_b <= b;
                    alu_op <= (legal && !dz) ? op : 4'd0;
                    err_q <= !legal || dz;
                    dz_q <= legal && dz;
                end
                EXEC: begin
                    state <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_id <= id_q;
                    rsp_err <= err_q;
                    rsp_result <= err_q ? {16{dz_q}} : alu_result;
                end
                DONE: begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a behavioural ALU and hand-computed responses
module tb_alu_arbiter;
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0] req0_op = 0, req1_op = 0, alu_op;
    logic [15:0] alu_a, alu_b, alu_result, rsp_result;
    logic rsp_valid, rsp_id, rsp_err;
    int errors = 0, checks = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // divide by zero returns 1234 and opcode 0 returns BEEF so pass-through vs trap is visible
    always_comb
        alu_result = alu_op == 4'd1 ? alu_a + alu_b :
                     alu_op == 4'd2 ? alu_a - alu_b :
                     alu_op == 4'd3 ? alu_a * alu_b :
                     alu_op == 4'd4 ? (alu_b == 0 ? 16'h1234 : alu_a / alu_b) : 16'hBEEF;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ready"}, {14'd0, req1_ready, req0_ready}, 16'd0);
        chk({tag, " alu_a"}, alu_a, 16'd0);
        chk({tag, " alu_b"}, alu_b, 16'd0);
        chk({tag, " alu_op"}, {12'd0, alu_op}, 16'd0);
        chk({tag, " rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
        chk({tag, " rsp_id"}, {15'd0, rsp_id}, 16'd0);
        chk({tag, " rsp_result"}, rsp_result, 16'd0);
        chk({tag, " rsp_err"}, {15'd0, rsp_err}, 16'd0);
    endtask

    // called at a negedge in IDLE with inputs already settled; returns at the negedge back in IDLE
    task automatic run_one(input string tag, input logic id, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [3:0] eop, input logic [15:0] eres, input logic eerr);
        chk({tag, " grant"}, {14'd0, req1_ready, req0_ready}, id ? 16'd2 : 16'd1);
        @(negedge clk);
        chk({tag, " exec alu_a"}, alu_a, ea);
        chk({tag, " exec alu_b"}, alu_b, eb);
        chk({tag, " exec alu_op"}, {12'd0, alu_op}, {12'd0, eop});
        chk({tag, " exec rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
        chk({tag, " exec ready"}, {14'd0, req1_ready, req0_ready}, 16'd0);
        @(negedge clk);
        chk({tag, " done rsp_valid"}, {15'd0, rsp_valid}, 16'd1);
        chk({tag, " done rsp_id"}, {15'd0, rsp_id}, {15'd0, id});
        chk({tag, " done rsp_result"}, rsp_result, eres);
        chk({tag, " done rsp_err"}, {15'd0, rsp_err}, {15'd0, eerr});
        chk({tag, " done ready"}, {14'd0, req1_ready, req0_ready}, 16'd0);
        @(negedge clk);
        chk({tag, " idle rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
        chk({tag, " idle rsp_result hold"}, rsp_result, eres);
    endtask

    initial begin
        req0_valid = 1; req1_valid = 1;
        req0_a = 10; req0_b = 3; req0_op = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 0; req1_valid = 0; #1;
        run_one("req0 add", 0, 10, 3, 4'd1, 16'd13, 0);
        req0_valid = 0;
        req1_valid = 1; req1_a = 10; req1_b = 3; req1_op = 4'd2; #1;
        run_one("req1 sub", 1, 10, 3, 4'd2, 16'd7, 0);
        req1_a = 6; req1_b = 7; req1_op = 4'd3; #1;
        run_one("req1 mul", 1, 6, 7, 4'd3, 16'd42, 0);
        req1_a = 20; req1_b = 4; req1_op = 4'd4; #1;
        run_one("req1 div", 1, 20, 4, 4'd4, 16'd5, 0);
        req1_valid = 0;
        req0_valid = 1; req0_a = 16'hFFFF; req0_b = 2; req0_op = 4'd1; #1;
        run_one("add overflow", 0, 16'hFFFF, 2, 4'd1, 16'd1, 0);
        req0_valid = 0;
        req1_valid = 1; req1_a = 5; req1_b = 5; req1_op = 4'hF; #1;
        run_one("illegal op", 1, 5, 5, 4'd0, 16'd0, 1);
        req1_valid = 0;
        req0_valid = 1; req0_a = 5; req0_b = 0; req0_op = 4'd4; #1;
`ifdef DIV_ZERO_CHECK_EN
        run_one("div zero trap", 0, 5, 0, 4'd0, 16'hFFFF, 1);
`else
        run_one("div zero pass", 0, 5, 0, 4'd4, 16'h1234, 0);
`endif
        // abort an op in EXEC; last grant was req0, reset must restore req0 priority
        req0_a = 1; req0_b = 1; req0_op = 4'd1; #1;
        chk("abort grant", {14'd0, req1_ready, req0_ready}, 16'd1);
        @(negedge clk);
        chk("abort in exec", {12'd0, alu_op}, 16'd1);
        rst = 1; req0_valid = 0;
        @(negedge clk);
        chk_zero("abort");
        rst = 0;
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 4'd1;
        req1_valid = 1; req1_a = 9; req1_b = 2; req1_op = 4'd3; #1;
        chk("abort no rsp", {15'd0, rsp_valid}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_one("rr req0", 0, 3, 4, 4'd1, 16'd7, 0);
            else run_one("rr req1", 1, 9, 2, 4'd3, 16'd18, 0);
            #1;
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
